axis_uart_tx_arbiter: RTL and testbench
=======================================

AXIS_UART_TX_ARBITER -- requirements
Module: axis_uart_tx_arbiter

Interface
REQ-001 Parameter N_BYTES, default 32, output word width in bytes; SHALL be 2..64 and SHALL match the downstream UART bridge N_BYTES.
REQ-002 Parameter N_PORTS, default 4, number of requester streams; SHALL be 2..16.
REQ-003 Port aclk  input  1  single clock; all logic SHALL be rising-edge aclk.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port S_AXIS_TDATA  input  N_PORTS*(N_BYTES-1)*8  requester payloads; port p occupies bits [(p+1)*(N_BYTES-1)*8-1 : p*(N_BYTES-1)*8].
REQ-006 Port S_AXIS_TVALID  input  N_PORTS  per-requester valid.
REQ-007 Port S_AXIS_TREADY  output  N_PORTS  per-requester ready.
REQ-008 Port M_AXIS_TDATA  output  N_BYTES*8  tagged word toward the UART bridge TX input.
REQ-009 Port M_AXIS_TVALID  output  1  output valid.
REQ-010 Port M_AXIS_TREADY  input  1  output ready from the bridge.
REQ-011 Port LAST_GRANT  output  4  index of the most recently accepted requester.
REQ-012 Port BUSY  output  1  high while a word is held in the output register.

Function
REQ-013 FSM SHALL have two states: IDLE and SEND.
REQ-014 In IDLE with no S_AXIS_TVALID bit set, all S_AXIS_TREADY bits SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-015 In IDLE with at least one TVALID bit set, the arbiter SHALL select the first set bit, searching from index LAST_GRANT+1 upward with wrap from N_PORTS-1 to 0.
REQ-016 In that same cycle, S_AXIS_TREADY SHALL be 1 for the selected port only (one-hot, or all zero).
REQ-017 On that handshake, M_AXIS_TDATA SHALL be registered as {8-bit port index, selected payload}, with the index in the top byte, zero-extended.
REQ-018 On that handshake, LAST_GRANT SHALL be loaded with the selected index and the FSM SHALL move to SEND.
REQ-019 Latency SHALL be 1 cycle: M_AXIS_TVALID=1 in the cycle after the input handshake.
REQ-020 In SEND, M_AXIS_TVALID SHALL stay 1, and M_AXIS_TDATA SHALL stay stable, until M_AXIS_TREADY=1.
REQ-021 In SEND, all S_AXIS_TREADY bits SHALL be 0.
REQ-022 On the SEND output handshake, the FSM SHALL return to IDLE; peak throughput is one word per 2 cycles.
REQ-023 A requester that deasserts TVALID before it is granted SHALL lose no state; arbitration SHALL use current TVALID only.
REQ-024 Single requester continuously valid: it SHALL be granted on every IDLE visit.
REQ-025 All N_PORTS requesters continuously valid: the grant order SHALL be strictly cyclic, so no port waits more than N_PORTS grants.
REQ-026 BUSY SHALL equal the SEND state; BUSY SHALL be identical to M_AXIS_TVALID.

Reset
REQ-027 While reset=1: FSM = IDLE, M_AXIS_TVALID=0, all S_AXIS_TREADY bits = 0, M_AXIS_TDATA=0, LAST_GRANT=N_PORTS-1 (so port 0 has first priority), BUSY=0.
REQ-028 Reset asserted in SEND SHALL discard the held word; M_AXIS_TVALID SHALL be 0 in the cycle after reset is sampled.
REQ-029 Reset SHALL take precedence over any simultaneous handshake.

Structure
REQ-030 Package axis_uart_bridge_pkg SHALL hold the FSM state enum (IDLE, SEND) and the header-width constant (8).
REQ-031 A combinational sub-module axis_rr_select SHALL compute the rotating-priority one-hot grant and its index from the request vector and the last grant.
REQ-032 The output register and FSM SHALL reside in axis_uart_tx_arbiter.

Verification
REQ-033 Reset release with all TVALID=0 for 10 cycles -> S_AXIS_TREADY=0000, M_AXIS_TVALID=0, LAST_GRANT=3.
REQ-034 Only port 2 valid, payload 0xA5 repeated, M_AXIS_TREADY=1 -> M_AXIS_TDATA top byte 0x02, words at cycles t+1, t+3, t+5.
REQ-035 Ports 0..3 all valid, M_AXIS_TREADY=1 -> grants 0,1,2,3,0,1 in order; tags 0x00..0x03.
REQ-036 Port 1 granted, M_AXIS_TREADY=0 for 20 cycles -> TDATA stable, TVALID=1, TREADY=0000 throughout; word delivered on the first ready cycle.
REQ-037 Reset pulsed in SEND with word 0x01_xx pending -> M_AXIS_TVALID=0 next cycle, no delivery; next grant goes to port 0 if valid.
REQ-038 LAST_GRANT=3, ports 0 and 3 valid -> port 0 granted (wrap-around).

Source files
------------

// File: rtl/axis_uart_bridge_pkg.sv
// Shared types for the UART bridge TX arbiter.
// State encoding and the tag header width.
package axis_uart_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int HDR_W = 8;

endpackage

// File: rtl/axis_uart_tx_arbiter_if.sv
// Stream bundle between requesters, the arbiter and the UART bridge.
// Member names follow the bridge's AXIS port naming.
interface axis_uart_tx_arbiter_if #(
  parameter int N_BYTES = 32,
  parameter int N_PORTS = 4
);

  localparam int PW = (N_BYTES - 1) * 8;

  logic [N_PORTS*PW-1:0] S_AXIS_TDATA;
  logic [N_PORTS-1:0]    S_AXIS_TVALID;
  logic [N_PORTS-1:0]    S_AXIS_TREADY;
  logic [N_BYTES*8-1:0]  M_AXIS_TDATA;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TREADY;
  logic [3:0]            LAST_GRANT;
  logic                  BUSY;

  modport master (
    input  S_AXIS_TDATA,
    input  S_AXIS_TVALID,
    input  M_AXIS_TREADY,
    output S_AXIS_TREADY,
    output M_AXIS_TDATA,
    output M_AXIS_TVALID,
    output LAST_GRANT,
    output BUSY
  );

  modport slave (
    output S_AXIS_TDATA,
    output S_AXIS_TVALID,
    output M_AXIS_TREADY,
    input  S_AXIS_TREADY,
    input  M_AXIS_TDATA,
    input  M_AXIS_TVALID,
    input  LAST_GRANT,
    input  BUSY
  );

endinterface

// File: rtl/axis_rr_select.sv
// Rotating-priority selector: picks the requester closest
// after the last grant, wrapping at N_PORTS-1.
module axis_rr_select #(
  parameter int N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [3:0]         i_last,
  output logic [N_PORTS-1:0] o_grant,
  output logic [3:0]         o_idx,
  output logic               o_valid
);

  int w_d;
  int w_best;

  always_comb begin
    w_d     = 0;
    w_best  = N_PORTS;
    o_idx   = '0;
    o_valid = 1'b0;
    o_grant = '0;
    // distance 0 is the port right after the last grant
    for (int p = 0; p < N_PORTS; p++) begin
      w_d = (p + 2 * N_PORTS - int'(i_last) - 1) % N_PORTS;
      if (i_req[p] && (w_d < w_best)) begin
        w_best  = w_d;
        o_idx   = 4'(p);
        o_valid = 1'b1;
      end
    end
    for (int p = 0; p < N_PORTS; p++) begin
      o_grant[p] = o_valid && (o_idx == 4'(p));
    end
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Round-robin N-to-1 stream arbiter that tags each word with
// its source port index and holds it until the bridge accepts.
module axis_uart_tx_arbiter
  import axis_uart_bridge_pkg::*;
#(
  parameter int N_BYTES = 32,
  parameter int N_PORTS = 4
) (
  input logic                   aclk,
  input logic                   reset,
  axis_uart_tx_arbiter_if.master bus
);

  localparam int PW = (N_BYTES - 1) * 8;

  state_t               r_state;
  state_t               w_next;
  logic [N_BYTES*8-1:0] r_tdata;
  logic [3:0]           r_last;
  logic [N_PORTS-1:0]   w_grant;
  logic [N_PORTS-1:0]   w_tready;
  logic [3:0]           w_idx;
  logic                 w_any;
  logic                 w_load;

  axis_rr_select #(
    .N_PORTS (N_PORTS)
  ) u_sel (
    .i_req   (bus.S_AXIS_TVALID),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_tready = '0;
    unique case (r_state)
      IDLE: begin
        // no handshake is offered while reset is held
        if (w_any && !reset) begin
          w_load   = 1'b1;
          w_tready = w_grant;
          w_next   = SEND;
        end
      end
      SEND: begin
        if (bus.M_AXIS_TREADY) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tdata <= '0;
      r_last  <= 4'(N_PORTS - 1);
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_tdata <= {HDR_W'(w_idx),
                    bus.S_AXIS_TDATA[int'(w_idx)*PW +: PW]};
        r_last  <= w_idx;
      end
    end
  end

  assign bus.S_AXIS_TREADY = w_tready;
  assign bus.M_AXIS_TDATA  = r_tdata;
  assign bus.M_AXIS_TVALID = (r_state == SEND);
  assign bus.BUSY          = (r_state == SEND);
  assign bus.LAST_GRANT    = r_last;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level model.
module tb_axis_uart_tx_arbiter;

  localparam int NB = 32;
  localparam int NP = 4;
  localparam int PW = (NB - 1) * 8;
  localparam int W  = NB * 8;

  logic aclk = 1'b0;
  logic reset;

  always #5 aclk = ~aclk;

  axis_uart_tx_arbiter_if #(.N_BYTES(NB), .N_PORTS(NP)) bus ();

  axis_uart_tx_arbiter #(
    .N_BYTES (NB),
    .N_PORTS (NP)
  ) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int            m_last;
  bit            m_busy;
  logic [W-1:0]  m_word;
  int            m_deliv;
  logic [PW-1:0] pay [NP];

  typedef struct {
    logic [3:0] v;
    bit         mr;
    logic [3:0] rdy;
    bit         mv;
    logic [3:0] lg;
    logic [7:0] tag;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // first requester after 'last' going upward with wrap
  function automatic int pick(logic [NP-1:0] v, int last);
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (last + k) % NP;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic tick(bit rst, logic [NP-1:0] v, bit mr);
    int g;
    logic [NP-1:0] er;
    @(negedge aclk);
    reset = rst;
    bus.S_AXIS_TVALID = v;
    bus.M_AXIS_TREADY = mr;
    for (int p = 0; p < NP; p++) bus.S_AXIS_TDATA[p*PW +: PW] = pay[p];
    #1;
    g  = pick(v, m_last);
    er = '0;
    if (!rst && !m_busy && g >= 0) er = NP'(1) << g;
    chk("tready", W'(bus.S_AXIS_TREADY), W'(er));
    chk("mvalid", W'(bus.M_AXIS_TVALID), W'(m_busy));
    chk("busy", W'(bus.BUSY), W'(m_busy));
    chk("last_grant", W'(bus.LAST_GRANT), W'(m_last));
    chk("tdata", bus.M_AXIS_TDATA, m_word);
    if (rst) begin
      m_last = NP - 1;
      m_busy = 1'b0;
      m_word = '0;
    end else if (m_busy) begin
      if (mr) begin
        m_busy = 1'b0;
        m_deliv++;
      end
    end else if (g >= 0) begin
      m_busy = 1'b1;
      m_last = g;
      m_word = {8'(g), pay[g]};
    end
  endtask

  logic [W-1:0] w_exp;

  initial begin
    reset = 1'b1;
    bus.S_AXIS_TVALID = '0;
    bus.M_AXIS_TREADY = 1'b0;
    bus.S_AXIS_TDATA  = '0;
    for (int p = 0; p < NP; p++) pay[p] = {31{8'(8'hA0 + p)}};
    m_last  = NP - 1;
    m_busy  = 1'b0;
    m_word  = '0;
    m_deliv = 0;
    repeat (2) @(posedge aclk);

    // reset release, idle
    tick(1, 4'b1111, 1);
    for (int i = 0; i < 10; i++) begin
      tick(0, 4'b0000, 0);
      chk("idle_tready", W'(bus.S_AXIS_TREADY), W'(4'b0000));
      chk("idle_mvalid", W'(bus.M_AXIS_TVALID), W'(1'b0));
      chk("idle_last", W'(bus.LAST_GRANT), W'(4'd3));
    end

    // table: cyclic grants, wrap, hold
    tbl[0]  = '{4'b1111, 1, 4'b0001, 0, 4'd3, 8'h00};
    tbl[1]  = '{4'b1111, 1, 4'b0000, 1, 4'd0, 8'h00};
    tbl[2]  = '{4'b1111, 1, 4'b0010, 0, 4'd0, 8'h00};
    tbl[3]  = '{4'b1111, 1, 4'b0000, 1, 4'd1, 8'h01};
    tbl[4]  = '{4'b1111, 1, 4'b0100, 0, 4'd1, 8'h00};
    tbl[5]  = '{4'b1111, 1, 4'b0000, 1, 4'd2, 8'h02};
    tbl[6]  = '{4'b1111, 1, 4'b1000, 0, 4'd2, 8'h00};
    tbl[7]  = '{4'b1111, 1, 4'b0000, 1, 4'd3, 8'h03};
    tbl[8]  = '{4'b1111, 1, 4'b0001, 0, 4'd3, 8'h00};
    tbl[9]  = '{4'b1111, 1, 4'b0000, 1, 4'd0, 8'h00};
    tbl[10] = '{4'b1111, 1, 4'b0010, 0, 4'd0, 8'h00};
    tbl[11] = '{4'b1111, 1, 4'b0000, 1, 4'd1, 8'h01};
    tbl[12] = '{4'b1000, 1, 4'b1000, 0, 4'd1, 8'h00};
    tbl[13] = '{4'b1000, 1, 4'b0000, 1, 4'd3, 8'h03};
    tbl[14] = '{4'b1001, 1, 4'b0001, 0, 4'd3, 8'h00};
    tbl[15] = '{4'b1001, 1, 4'b0000, 1, 4'd0, 8'h00};
    tbl[16] = '{4'b1111, 0, 4'b0010, 0, 4'd0, 8'h00};
    tbl[17] = '{4'b1111, 0, 4'b0000, 1, 4'd1, 8'h01};
    tbl[18] = '{4'b1111, 0, 4'b0000, 1, 4'd1, 8'h01};
    tbl[19] = '{4'b1111, 1, 4'b0000, 1, 4'd1, 8'h01};
    tbl[20] = '{4'b0000, 1, 4'b0000, 0, 4'd1, 8'h00};
    tick(1, 4'b0000, 1);
    for (int i = 0; i < 21; i++) begin
      tick(0, tbl[i].v, tbl[i].mr);
      chk($sformatf("tbl%0d_tready", i), W'(bus.S_AXIS_TREADY), W'(tbl[i].rdy));
      chk($sformatf("tbl%0d_mvalid", i), W'(bus.M_AXIS_TVALID), W'(tbl[i].mv));
      chk($sformatf("tbl%0d_last", i), W'(bus.LAST_GRANT), W'(tbl[i].lg));
      if (tbl[i].mv)
        chk($sformatf("tbl%0d_tag", i), W'(bus.M_AXIS_TDATA[W-1 -: 8]), W'(tbl[i].tag));
    end

    // single requester port 2, one word every two cycles
    tick(1, 4'b0000, 1);
    pay[2] = {31{8'hA5}};
    w_exp  = {8'h02, {31{8'hA5}}};
    for (int i = 0; i < 6; i++) begin
      tick(0, 4'b0100, 1);
      chk($sformatf("p2_mvalid%0d", i), W'(bus.M_AXIS_TVALID), W'(i % 2));
      if (i % 2 == 1) chk($sformatf("p2_word%0d", i), bus.M_AXIS_TDATA, w_exp);
    end

    // port 1 held under 20 cycles of backpressure
    tick(1, 4'b0000, 0);
    pay[1] = {31{8'h3C}};
    w_exp  = {8'h01, {31{8'h3C}}};
    tick(0, 4'b0010, 0);
    chk("bp_grant", W'(bus.S_AXIS_TREADY), W'(4'b0010));
    for (int i = 0; i < 20; i++) begin
      pay[1] = PW'({8{$urandom()}});
      tick(0, 4'b1111, 0);
      chk("bp_tdata", bus.M_AXIS_TDATA, w_exp);
      chk("bp_mvalid", W'(bus.M_AXIS_TVALID), W'(1'b1));
      chk("bp_tready", W'(bus.S_AXIS_TREADY), W'(4'b0000));
    end
    tick(0, 4'b0000, 1);
    chk("bp_deliver", bus.M_AXIS_TDATA, w_exp);
    tick(0, 4'b0000, 0);
    chk("bp_after", W'(bus.M_AXIS_TVALID), W'(1'b0));

    // reset while a port-1 word is pending
    tick(1, 4'b0000, 0);
    tick(0, 4'b0010, 0);
    tick(0, 4'b0010, 0);
    tick(1, 4'b1111, 1);
    tick(0, 4'b1111, 1);
    chk("rst_mvalid", W'(bus.M_AXIS_TVALID), W'(1'b0));
    chk("rst_last", W'(bus.LAST_GRANT), W'(4'd3));
    chk("rst_regrant", W'(bus.S_AXIS_TREADY), W'(4'b0001));

    // random traffic against the model
    tick(1, 4'b0000, 0);
    m_deliv = 0;
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < NP; p++) pay[p] = PW'({8{$urandom()}});
      tick($urandom_range(0, 59) == 0, 4'($urandom()), $urandom_range(0, 3) != 0);
    end
    n_cmp++;
    if (m_deliv < 100) begin
      n_bad++;
      $display("FAIL rand_deliveries: got %0d want >= 100", m_deliv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
